// File: rtl/usart_pkg.sv
// Shared USART definitions: baud-engine FSM states and default divisors
// for the 50 MHz system clock.
package usart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } usart_state_e;

    // 50 MHz / baud, fractional part in 1/16 clock (FRAC_W = 4)
    localparam logic [15:0] DIV_INT_57600   = 16'd868;
    localparam logic [3:0]  DIV_FRAC_57600  = 4'd1;
    localparam logic [15:0] DIV_INT_115200  = 16'd434;
    localparam logic [3:0]  DIV_FRAC_115200 = 4'd0;

endpackage

// File: rtl/usart_frac_phase.sv
// Fractional bit-length generator: accumulates the fractional divisor and
// turns the carry into a one-clock stretch of the current bit.
module usart_frac_phase #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              restart_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic [DIV_W:0]    len_o,
    output logic [DIV_W:0]    half_o
);

    logic [FRAC_W-1:0] acc_q, acc_d, acc_base;
    logic [FRAC_W:0]   sum;
    logic [DIV_W:0]    len_q, len_d;

    // restart computes the first bit of a frame from a zero accumulator
    always_comb begin
        acc_base = restart_i ? '0 : acc_q;
        sum      = {1'b0, acc_base} + {1'b0, div_frac_i};
        acc_d    = sum[FRAC_W-1:0];
        len_d    = {1'b0, div_int_i} + {{DIV_W{1'b0}}, sum[FRAC_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            len_q <= '0;
        end else if (load_i) begin
            acc_q <= acc_d;
            len_q <= len_d;
        end
    end

    assign len_o  = len_q;
    assign half_o = len_q >> 1;

endmodule

// File: rtl/usart_baud_engine.sv
// Programmable fractional baud engine: mid-bit sample and end-of-bit strobes,
// bit counting and frame completion for the USART TX/RX controllers.
module usart_baud_engine
    import usart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int BITS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic [BITS_W-1:0] cfg_bits,
    output logic              busy,
    output logic              sample,
    output logic              bit_end,
    output logic [BITS_W-1:0] bit_idx,
    output logic              frame_done,
    output usart_state_e      dbg_state
);

    localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);
    localparam logic [DIV_W:0]    LEN_ONE  = (DIV_W+1)'(1);
    localparam logic [BITS_W-1:0] BITS_ONE = BITS_W'(1);

    usart_state_e      state_q;
    logic [DIV_W:0]    cnt_q;
    logic [BITS_W-1:0] bit_idx_q;
    logic [DIV_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [BITS_W-1:0] bits_q;
    logic              busy_q, sample_q, bit_end_q, frame_done_q;

    logic [DIV_W-1:0]  cfg_div_eff, ph_div_int;
    logic [FRAC_W-1:0] ph_div_frac;
    logic [BITS_W-1:0] cfg_bits_eff;
    logic [DIV_W:0]    len, half;
    logic              start, resync_hit, last_cnt, last_bit, bit_adv;
    logic              ph_load, ph_restart;

    // The phase unit sees live config on the start edge, shadow copies after
    always_comb begin
        cfg_div_eff  = (cfg_div_int < MIN_DIV) ? MIN_DIV : cfg_div_int;
        cfg_bits_eff = (cfg_bits == '0) ? BITS_ONE : cfg_bits;
        start        = (state_q == ST_IDLE) && en;
        resync_hit   = (state_q == ST_RUN) && en && resync;
        last_cnt     = (cnt_q == len - LEN_ONE);
        last_bit     = (bit_idx_q == bits_q - BITS_ONE);
        bit_adv      = (state_q == ST_RUN) && en && !resync && last_cnt && !last_bit;
        ph_load      = start || resync_hit || bit_adv;
        ph_restart   = start || resync_hit;
        ph_div_int   = start ? cfg_div_eff : div_int_q;
        ph_div_frac  = start ? cfg_div_frac : div_frac_q;
    end

    usart_frac_phase #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ph_load),
        .restart_i  (ph_restart),
        .div_int_i  (ph_div_int),
        .div_frac_i (ph_div_frac),
        .len_o      (len),
        .half_o     (half)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            div_int_q    <= MIN_DIV;
            div_frac_q   <= '0;
            bits_q       <= BITS_ONE;
            busy_q       <= 1'b0;
            sample_q     <= 1'b0;
            bit_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sample_q     <= 1'b0;
            bit_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        div_int_q  <= cfg_div_eff;
                        div_frac_q <= cfg_div_frac;
                        bits_q     <= cfg_bits_eff;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                    end else if (resync) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                    end else begin
                        sample_q <= (cnt_q == half);
                        if (last_cnt) begin
                            bit_end_q <= 1'b1;
                            cnt_q     <= '0;
                            if (last_bit) begin
                                frame_done_q <= 1'b1;
                                state_q      <= ST_DONE;
                                busy_q       <= 1'b0;
                            end else begin
                                bit_idx_q <= bit_idx_q + BITS_ONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + LEN_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        state_q   <= ST_IDLE;
                        bit_idx_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign sample     = sample_q;
    assign bit_end    = bit_end_q;
    assign bit_idx    = bit_idx_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_usart_baud_engine.sv
// Directed bench for usart_baud_engine: integer/fractional periods, resync,
// enable drop, degenerate config and asynchronous reset.
module tb_usart_baud_engine;
    import usart_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         resync;
    logic [15:0]  cfg_div_int;
    logic [3:0]   cfg_div_frac;
    logic [3:0]   cfg_bits;
    logic         busy, sample, bit_end, frame_done;
    logic [3:0]   bit_idx;
    usart_state_e dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int sm_q[$];
    int be_q[$];
    int fd_q[$];
    logic [31:0] exp_q[$];

    usart_baud_engine #(
        .DIV_W  (16),
        .FRAC_W (4),
        .BITS_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .resync       (resync),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_bits     (cfg_bits),
        .busy         (busy),
        .sample       (sample),
        .bit_end      (bit_end),
        .bit_idx      (bit_idx),
        .frame_done   (frame_done),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver / checker tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] ov(input logic b, input logic s, input logic e,
                                      input logic f, input logic [3:0] idx);
        return {b, s, e, f, idx};
    endfunction

    function automatic logic [7:0] outv();
        return {busy, sample, bit_end, frame_done, bit_idx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // records the edge index of every strobe; index i means "after edge E(i)"
    task automatic watch(input int n);
        sm_q.delete();
        be_q.delete();
        fd_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sample)     sm_q.push_back(i);
            if (bit_end)    be_q.push_back(i);
            if (frame_done) fd_q.push_back(i);
        end
    endtask

    task automatic cmp_list(input string tag, input int got[$]);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; resync = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0; cfg_bits = '0;
        tick(2);
        chk("reset_outputs", outv(), ov(0, 0, 0, 0, 0));
        chk("reset_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick(2);
        chk("idle_no_en", outv(), ov(0, 0, 0, 0, 0));

        // integer divisor 10, 3 bits
        cfg_div_int = 16'd10; cfg_div_frac = 4'd0; cfg_bits = 4'd3; en = 1'b1;
        tick(1);  chk("int_e0",        outv(), ov(1, 0, 0, 0, 0));
        tick(5);  chk("int_e5",        outv(), ov(1, 0, 0, 0, 0));
        tick(1);  chk("int_e6_sample", outv(), ov(1, 1, 0, 0, 0));
        tick(1);  chk("int_e7",        outv(), ov(1, 0, 0, 0, 0));
        tick(3);  chk("int_e10_end",   outv(), ov(1, 0, 1, 0, 1));
        tick(6);  chk("int_e16_sample",outv(), ov(1, 1, 0, 0, 1));
        tick(4);  chk("int_e20_end",   outv(), ov(1, 0, 1, 0, 2));
        tick(6);  chk("int_e26_sample",outv(), ov(1, 1, 0, 0, 2));
        tick(4);  chk("int_e30_done",  outv(), ov(0, 0, 1, 1, 2));
        chk("int_state_done", dbg_state, ST_DONE);
        cfg_div_int = 16'd5;
        watch(40);
        chk("done_quiet_strobes", sm_q.size() + be_q.size() + fd_q.size(), 0);
        chk("done_hold", outv(), ov(0, 0, 0, 0, 2));
        en = 1'b0;
        tick(1);
        chk("done_to_idle", outv(), ov(0, 0, 0, 0, 0));
        chk("done_to_idle_state", dbg_state, ST_IDLE);
        tick(2);

        // fractional divisor 8.5, 4 bits: lengths 8,9,8,9
        cfg_div_int = 16'd8; cfg_div_frac = 4'd8; cfg_bits = 4'd4; en = 1'b1;
        watch(45);
        exp_q = '{32'd8, 32'd17, 32'd25, 32'd34};
        cmp_list("frac_bit_end", be_q);
        exp_q = '{32'd5, 32'd13, 32'd22, 32'd30};
        cmp_list("frac_sample", sm_q);
        exp_q = '{32'd34};
        cmp_list("frac_frame_done", fd_q);
        en = 1'b0;
        tick(2);

        // resync at cnt=4 of bit 1, then en dropped at cnt=3 of bit 2
        cfg_div_int = 16'd10; cfg_div_frac = 4'd0; cfg_bits = 4'd3; en = 1'b1;
        tick(15); chk("rs_before",       outv(), ov(1, 0, 0, 0, 1));
        resync = 1'b1;
        tick(1);  chk("rs_edge",         outv(), ov(1, 0, 0, 0, 0));
        resync = 1'b0;
        tick(5);  chk("rs_no_old_end",   outv(), ov(1, 0, 0, 0, 0));
        tick(1);  chk("rs_sample_plus6", outv(), ov(1, 1, 0, 0, 0));
        tick(4);  chk("rs_end_plus10",   outv(), ov(1, 0, 1, 0, 1));
        tick(13); chk("drop_before",     outv(), ov(1, 0, 0, 0, 2));
        en = 1'b0;
        tick(1);  chk("drop_after",      outv(), ov(0, 0, 0, 0, 0));
        chk("drop_state", dbg_state, ST_IDLE);
        cfg_div_int = 16'd20; en = 1'b1;
        watch(45);
        exp_q = '{32'd20, 32'd40};
        cmp_list("div20_bit_end", be_q);
        exp_q = '{32'd11, 32'd31};
        cmp_list("div20_sample", sm_q);
        chk("div20_no_frame_done", fd_q.size(), 0);
        en = 1'b0;
        tick(2);

        // resync on the last count of a bit suppresses its bit_end
        cfg_div_int = 16'd4; cfg_div_frac = 4'd0; cfg_bits = 4'd2; en = 1'b1;
        tick(4);  chk("sup_e3_sample",   outv(), ov(1, 1, 0, 0, 0));
        resync = 1'b1;
        tick(1);  chk("sup_e4_no_end",   outv(), ov(1, 0, 0, 0, 0));
        resync = 1'b0;
        tick(3);  chk("sup_e7_sample",   outv(), ov(1, 1, 0, 0, 0));
        tick(1);  chk("sup_e8_end",      outv(), ov(1, 0, 1, 0, 1));
        en = 1'b0;
        tick(1);
        resync = 1'b1;
        tick(2);  chk("idle_resync_ignored", outv(), ov(0, 0, 0, 0, 0));
        resync = 1'b0;

        // degenerate config behaves as divisor 2, one bit
        cfg_div_int = 16'd0; cfg_div_frac = 4'd0; cfg_bits = 4'd0; en = 1'b1;
        tick(2);  chk("deg_e1",   outv(), ov(1, 0, 0, 0, 0));
        tick(1);  chk("deg_e2",   outv(), ov(0, 1, 1, 1, 0));
        tick(1);  chk("deg_e3",   outv(), ov(0, 0, 0, 0, 0));
        en = 1'b0;
        tick(2);

        // asynchronous reset in the middle of a run
        cfg_div_int = 16'd10; cfg_div_frac = 4'd0; cfg_bits = 4'd3; en = 1'b1;
        tick(7);  chk("arst_pre", outv(), ov(1, 1, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1 chk("arst_async", outv(), ov(0, 0, 0, 0, 0));
        chk("arst_state", dbg_state, ST_IDLE);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);  chk("arst_idle_after", outv(), ov(0, 0, 0, 0, 0));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
